// File: rtl/loop_accum_regheap.sv
// loop_accum_regheap: per-lane signed accumulation over a runtime loop count, one registered result per group
module loop_accum_regheap #(
    parameter int LANES = 64,
    parameter int DW    = 16,
    parameter int CNT_W = 4,
    parameter int SAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    cfg_loop_num,
    input  logic                data_v,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                halt,
    input  logic                flush,
    output logic [LANES*DW-1:0] out_data,
    output logic                out_v,
    output logic [LANES-1:0]    ovf,
    output logic                busy
);

    logic [CNT_W-1:0]    beat_cnt, loop_lat, lat_eff, idx;
    logic [LANES*DW-1:0] acc, acc_nxt;
    logic [LANES-1:0]    sticky, sticky_nxt;
    logic                acc_en, first, last;

    // A flush restarts the group, so a beat arriving with it is treated as a first beat.
    assign acc_en  = data_v & ~halt;
    assign first   = (beat_cnt == '0) | flush;
    assign lat_eff = first ? ((cfg_loop_num == '0) ? CNT_W'(1) : cfg_loop_num) : loop_lat;
    assign idx     = first ? '0 : beat_cnt;
    assign last    = idx == lat_eff - CNT_W'(1);
    assign busy    = beat_cnt != '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0] a, b, res;
        logic [DW:0]   sum;
        logic          of;
        assign a   = acc[i*DW +: DW];
        assign b   = in_data[i*DW +: DW];
        assign sum = {a[DW-1], a} + {b[DW-1], b};
        assign of  = sum[DW] ^ sum[DW-1];
        assign res = (SAT != 0 && of) ? (sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                                      : sum[DW-1:0];
        assign acc_nxt[i*DW +: DW] = first ? b : res;
        assign sticky_nxt[i]       = ~first & (sticky[i] | of);
    end

    // Group accumulation, beat counting and result registering; halt freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            sticky   <= '0;
            beat_cnt <= '0;
            loop_lat <= '0;
            out_data <= '0;
            ovf      <= '0;
            out_v    <= 1'b0;
        end else if (!halt) begin
            out_v <= acc_en & last;
            if (acc_en) begin
                acc      <= acc_nxt;
                sticky   <= sticky_nxt;
                loop_lat <= lat_eff;
                beat_cnt <= last ? '0 : idx + CNT_W'(1);
                if (last) begin
                    out_data <= acc_nxt;
                    ovf      <= sticky_nxt;
                end
            end else if (flush) begin
                beat_cnt <= '0;
                sticky   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_loop_accum_regheap.sv
// tb_loop_accum_regheap: randomized and directed checks of saturating and wrapping instances against an arithmetic model
module tb_loop_accum_regheap;

    localparam int L  = 4;
    localparam int D  = 16;
    localparam int C  = 4;
    localparam int OW = 2 + 2*L*D + 2*L + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         data_v = 1'b0, halt = 1'b0, flush = 1'b0;
    logic [C-1:0] cfg_loop_num = '0;
    logic [L*D-1:0] in_data = '0;
    logic [L*D-1:0] ds, dw;
    logic           vs, vw, bs, bw;
    logic [L-1:0]   os, ow;

    loop_accum_regheap #(.LANES(L), .DW(D), .CNT_W(C), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .cfg_loop_num(cfg_loop_num), .data_v(data_v), .in_data(in_data),
        .halt(halt), .flush(flush), .out_data(ds), .out_v(vs), .ovf(os), .busy(bs));

    loop_accum_regheap #(.LANES(L), .DW(D), .CNT_W(C), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .cfg_loop_num(cfg_loop_num), .data_v(data_v), .in_data(in_data),
        .halt(halt), .flush(flush), .out_data(dw), .out_v(vw), .ovf(ow), .busy(bw));

    always #5 clk = ~clk;

    wire [OW-1:0] obs = {vs, vw, ds, dw, os, ow, bs, bw};
    logic [OW-1:0] expv;

    int in_lane[L];
    int m_cnt, m_lat;
    int m_as[L], m_aw[L], e_ds[L], e_dw[L];
    logic [L-1:0] m_so, m_wo, e_os, e_ow;
    logic e_v;
    int checks = 0, fails = 0;

    task automatic pack_exp();
        logic [L*D-1:0] ps, pw;
        for (int i = 0; i < L; i++) begin
            ps[i*D +: D] = e_ds[i][D-1:0];
            pw[i*D +: D] = e_dw[i][D-1:0];
        end
        expv = {e_v, e_v, ps, pw, e_os, e_ow, m_cnt != 0, m_cnt != 0};
    endtask

    task automatic model_reset();
        m_cnt = 0; m_lat = 0; e_v = 0;
        m_so = '0; m_wo = '0; e_os = '0; e_ow = '0;
        for (int i = 0; i < L; i++) begin
            m_as[i] = 0; m_aw[i] = 0; e_ds[i] = 0; e_dw[i] = 0;
        end
        pack_exp();
    endtask

    task automatic model_step();
        int s, w;
        if (!halt) begin
            e_v = 0;
            if (flush) begin
                m_cnt = 0; m_so = '0; m_wo = '0;
            end
            if (data_v) begin
                if (m_cnt == 0) begin
                    m_lat = (cfg_loop_num == 0) ? 1 : int'(cfg_loop_num);
                    m_so = '0; m_wo = '0;
                    for (int i = 0; i < L; i++) begin
                        m_as[i] = in_lane[i]; m_aw[i] = in_lane[i];
                    end
                end else begin
                    for (int i = 0; i < L; i++) begin
                        s = m_as[i] + in_lane[i];
                        if (s > 32767) begin s = 32767; m_so[i] = 1'b1; end
                        else if (s < -32768) begin s = -32768; m_so[i] = 1'b1; end
                        m_as[i] = s;
                        w = m_aw[i] + in_lane[i];
                        if (w > 32767) begin w -= 65536; m_wo[i] = 1'b1; end
                        else if (w < -32768) begin w += 65536; m_wo[i] = 1'b1; end
                        m_aw[i] = w;
                    end
                end
                m_cnt++;
                if (m_cnt == m_lat) begin
                    e_v = 1; e_ds = m_as; e_dw = m_aw; e_os = m_so; e_ow = m_wo; m_cnt = 0;
                end
            end
        end
        pack_exp();
    endtask

    task automatic cycle(input logic h, input logic f, input logic v);
        halt = h; flush = f; data_v = v;
        for (int i = 0; i < L; i++) in_data[i*D +: D] = in_lane[i][D-1:0];
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < L; i++) in_lane[i] = val;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin fails++; $display("FAIL reset: got %h exp 0", obs); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        cfg_loop_num = 3;
        for (int k = 1; k <= 3; k++) begin
            set_all(k);
            cycle(0, 0, 1);
            checks++;
            if (obs !== expv) begin fails++; $display("FAIL basic beat %0d: got %h exp %h", k, obs, expv); end
            if (k < 3) begin
                checks++;
                if (bs !== 1'b1) begin fails++; $display("FAIL basic busy beat %0d: got %b exp 1", k, bs); end
            end
        end
        checks++;
        if ({vs, ds, os} !== {1'b1, {L{16'd6}}, 4'b0}) begin
            fails++; $display("FAIL basic result: got %b %h %b exp 1 %h 0", vs, ds, os, {L{16'd6}});
        end
        cycle(0, 0, 0);
        checks++;
        if (vs !== 1'b0) begin fails++; $display("FAIL basic strobe drop: got %b exp 0", vs); end
    endtask

    task automatic test_overflow();
        int b0[2] = '{32'h7000, 32'h2000};
        int b1[2] = '{-32768, -1};
        cfg_loop_num = 2;
        for (int k = 0; k < 2; k++) begin
            set_all(0);
            in_lane[0] = b0[k]; in_lane[1] = b1[k];
            cycle(0, 0, 1);
            checks++;
            if (obs !== expv) begin fails++; $display("FAIL ovf beat %0d: got %h exp %h", k, obs, expv); end
        end
        checks++;
        if ({ds[31:0], os[1:0]} !== {32'h8000_7FFF, 2'b11}) begin
            fails++; $display("FAIL ovf sat: got %h %b exp 80007fff 11", ds[31:0], os[1:0]);
        end
        checks++;
        if ({dw[31:0], ow[1:0]} !== {32'h7FFF_9000, 2'b11}) begin
            fails++; $display("FAIL ovf wrap: got %h %b exp 7fff9000 11", dw[31:0], ow[1:0]);
        end
    endtask

    task automatic test_halt();
        cfg_loop_num = 3;
        for (int k = 0; k < 10; k++) begin
            logic h;
            h = (k >= 2 && k < 6) || k == 7 || k == 8;
            set_all(h ? 100 : (k < 2 ? k + 1 : 3));
            cycle(h, 0, (k < 7));
            checks++;
            if (obs !== expv) begin fails++; $display("FAIL halt cyc %0d: got %h exp %h", k, obs, expv); end
            if (k >= 6) begin
                checks++;
                if ({vs, ds} !== {(k < 9), {L{16'd6}}}) begin
                    fails++; $display("FAIL halt hold cyc %0d: got %b %h exp %b 6", k, vs, ds, (k < 9));
                end
            end
        end
    endtask

    task automatic test_flush();
        cfg_loop_num = 4;
        set_all(5);
        for (int k = 0; k < 7; k++) begin
            cycle(0, (k == 2), (k != 2));
            checks++;
            if (obs !== expv) begin fails++; $display("FAIL flush cyc %0d: got %h exp %h", k, obs, expv); end
            checks++;
            if (vs !== (k == 6)) begin fails++; $display("FAIL flush strobe cyc %0d: got %b exp %b", k, vs, (k == 6)); end
        end
        checks++;
        if (ds !== {L{16'd20}}) begin fails++; $display("FAIL flush result: got %h exp %h", ds, {L{16'd20}}); end
        set_all(1);
        for (int k = 0; k < 6; k++) begin
            cycle(0, (k == 2), 1);
            checks++;
            if (vs !== (k == 5)) begin fails++; $display("FAIL flush data strobe cyc %0d: got %b exp %b", k, vs, (k == 5)); end
        end
        checks++;
        if (obs !== expv || ds !== {L{16'd4}}) begin fails++; $display("FAIL flush data result: got %h exp %h", ds, {L{16'd4}}); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 5; k++) begin
            cfg_loop_num = (k == 1) ? 0 : 1;
            set_all(k);
            cycle(0, 0, 1);
            checks++;
            if ({vs, ds, bs} !== {1'b1, {L{k[15:0]}}, 1'b0} || obs !== expv) begin
                fails++; $display("FAIL b2b beat %0d: got %b %h exp 1 %h", k, vs, ds, {L{k[15:0]}});
            end
        end
        cycle(0, 0, 0);
        cfg_loop_num = 3;
        for (int k = 0; k < 3; k++) begin
            set_all(2);
            cycle(0, 0, 1);
            cfg_loop_num = 2;
            checks++;
            if (vs !== (k == 2) || obs !== expv) begin
                fails++; $display("FAIL cfg change beat %0d: got %b exp %b", k, vs, (k == 2));
            end
        end
    endtask

    task automatic test_async_reset();
        cfg_loop_num = 3;
        set_all(1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin fails++; $display("FAIL async reset: got %h exp 0", obs); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1);
            checks++;
            if (obs !== expv) begin fails++; $display("FAIL post reset beat %0d: got %h exp %h", k, obs, expv); end
        end
        checks++;
        if ({vs, ds} !== {1'b1, {L{16'd3}}}) begin fails++; $display("FAIL post reset result: got %b %h exp 1 %h", vs, ds, {L{16'd3}}); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(9) == 0) cfg_loop_num = C'($urandom_range(5));
            for (int i = 0; i < L; i++) in_lane[i] = int'($urandom_range(65535)) - 32768;
            cycle(($urandom_range(9) == 0), ($urandom_range(19) == 0), ($urandom_range(9) < 7));
            checks++;
            if (obs !== expv) begin fails++; $display("FAIL random cyc %0d: got %h exp %h", k, obs, expv); end
        end
    endtask

    initial begin
        set_all(0);
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_halt();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
